// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scanner.
// Hex-to-segment table (active-low a..g) and blank pattern.
package ssd_pkg;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,
    7'b0110000,
    7'b1000010,
    7'b0110001,
    7'b1100000,
    7'b0001000,
    7'b0000100,
    7'b0000000,
    7'b0001111,
    7'b0100000,
    7'b0100100,
    7'b1001100,
    7'b0000110,
    7'b0010010,
    7'b1001111,
    7'b0000001
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [3:0] AN_DIG0   = 4'b1110;

endpackage

// File: rtl/ssd_scan_hex7seg.sv
// Combinational hex digit to active-low segment decoder.
// Pure table lookup into the shared package.
module hex7seg
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading-zero digits 3..1.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        half_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          wrap_d;
  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick & (idx == 2'd3);
  assign nib  = snap[{idx, 2'b00} +: 4];

  hex7seg u_dec (
    .hex (nib),
    .seg (hex_seg)
  );

`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd3:    blank = (snap[15:12] == 4'h0);
      2'd2:    blank = (snap[15:8] == 8'h00);
      2'd1:    blank = (snap[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign an_nxt  = blank ? AN_OFF : ~(4'b0001 << idx);
  assign seg_nxt = blank ? SEG_BLANK : hex_seg;

  // Outputs lag the index/snapshot by one cycle; frame_done aligns with digit 0
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      wrap_d     <= 1'b0;
      an         <= AN_DIG0;
      seg        <= HEX_SEG[0];
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      if (wrap)
        snap <= half_sel ? value_in[31:16] : value_in[15:0];
      wrap_d     <= wrap;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= wrap_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// Directed self-checking bench for ssd_scan at REFRESH_DIV=4.
// Expected patterns are hand-written constants.
module tb_ssd_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value_in = 32'h0;
  logic        half_sel = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  ssd_scan #(.REFRESH_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .value_in   (value_in),
    .half_sel   (half_sel),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input logic [31:0] v, input logic hs);
    value_in = v;
    half_sel = hs;
    reset    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ea;
    logic [6:0] es;
    do_reset(32'h0, 1'b0);
    tests++;
    if (an !== 4'b1110 || seg !== 7'b0000001 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: an=%b seg=%b fd=%b need 1110 0000001 0",
               an, seg, frame_done);
    end
    cyc(4);
    tests++;
    if (an !== 4'b1110) begin
      fails++;
      $display("FAIL reset_hold: an=%b need 1110", an);
    end
    cyc(1);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    ea = 4'b1111; es = 7'b1111111;
`else
    ea = 4'b1101; es = 7'b0000001;
`endif
    tests++;
    if (an !== ea || seg !== es) begin
      fails++;
      $display("FAIL reset_first_adv: an=%b seg=%b need %b %b", an, seg, ea, es);
    end
  endtask

  task automatic test_scan;
    logic [3:0] ea [4];
    logic [6:0] es [4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    do_reset(32'h0000_1234, 1'b0);
    cyc(17);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (an !== ea[d] || seg !== es[d] ||
            frame_done !== (d == 0 && k == 0)) begin
          fails++;
          $display("FAIL scan d%0d c%0d: an=%b seg=%b fd=%b need %b %b %b",
                   d, k, an, seg, frame_done, ea[d], es[d], (d == 0 && k == 0));
        end
        cyc(1);
      end
    end
  endtask

  task automatic test_half_sel;
    logic [3:0] ea [4];
    logic [6:0] es [4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es = '{7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000};
    do_reset(32'hABCD_0000, 1'b1);
    cyc(17);
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (an !== ea[d] || seg !== es[d]) begin
        fails++;
        $display("FAIL half d%0d: an=%b seg=%b need %b %b",
                 d, an, seg, ea[d], es[d]);
      end
      cyc(4);
    end
    for (int k = 16; k <= 48; k++) begin
      tests++;
      if (frame_done !== (k % 16 == 0)) begin
        fails++;
        $display("FAIL frame_period k%0d: fd=%b need %b",
                 k, frame_done, (k % 16 == 0));
      end
      cyc(1);
    end
  endtask

  task automatic test_tear_free;
    do_reset(32'h0000_1111, 1'b0);
    cyc(17 + 8);
    value_in = 32'h0000_2222;
    tests++;
    if (an !== 4'b1011 || seg !== 7'b1001111) begin
      fails++;
      $display("FAIL tear_d2: an=%b seg=%b need 1011 1001111", an, seg);
    end
    cyc(4);
    tests++;
    if (an !== 4'b0111 || seg !== 7'b1001111) begin
      fails++;
      $display("FAIL tear_d3: an=%b seg=%b need 0111 1001111", an, seg);
    end
    cyc(4);
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (an !== ~(4'b0001 << d) || seg !== 7'b0010010 ||
          frame_done !== (d == 0)) begin
        fails++;
        $display("FAIL tear_new d%0d: an=%b seg=%b fd=%b need %b 0010010 %b",
                 d, an, seg, frame_done, ~(4'b0001 << d), (d == 0));
      end
      cyc(4);
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] ea;
    logic [6:0] es;
    do_reset(32'h0000_1234, 1'b0);
    cyc(17 + 8);
    value_in = 32'h0000_9999;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    tests++;
    if (an !== 4'b1110 || seg !== 7'b0000001 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst: an=%b seg=%b fd=%b need 1110 0000001 0",
               an, seg, frame_done);
    end
    cyc(5);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    ea = 4'b1111; es = 7'b1111111;
`else
    ea = 4'b1101; es = 7'b0000001;
`endif
    tests++;
    if (an !== ea || seg !== es) begin
      fails++;
      $display("FAIL midrst_snap0: an=%b seg=%b need %b %b", an, seg, ea, es);
    end
  endtask

  task automatic test_blank;
    logic [3:0] ea;
    logic [6:0] es;
    do_reset(32'h0000_0005, 1'b0);
    cyc(17);
    tests++;
    if (an !== 4'b1110 || seg !== 7'b0100100) begin
      fails++;
      $display("FAIL blank_d0: an=%b seg=%b need 1110 0100100", an, seg);
    end
    for (int d = 1; d < 4; d++) begin
      cyc(4);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      ea = 4'b1111; es = 7'b1111111;
`else
      ea = ~(4'b0001 << d); es = 7'b0000001;
`endif
      tests++;
      if (an !== ea || seg !== es) begin
        fails++;
        $display("FAIL blank_d%0d: an=%b seg=%b need %b %b", d, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_half_sel;
    test_tear_free;
    test_mid_reset;
    test_blank;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is displayed (legal range 2..2^20).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value_in  input  32  word to display (CPU data-memory word or register-file word).
REQ-005 SHALL have port half_sel  input  1  0 = display value_in[15:0], 1 = display value_in[31:16].
REQ-006 SHALL have port an  output  4  digit anodes, active-low one-hot; an[0] = least-significant digit.
REQ-007 SHALL have port seg  output  7  segments, active-low, seg[6]..seg[0] = a,b,c,d,e,f,g.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse at the end of each 4-digit scan frame.

Function
REQ-009 SHALL run a divider counter 0..REFRESH_DIV-1 that wraps to 0; "tick" = counter at REFRESH_DIV-1.
REQ-010 SHALL advance a 2-bit digit index 0->1->2->3->0 on each tick, and hold it otherwise.
REQ-011 SHALL load a 16-bit snapshot from the half of value_in selected by half_sel on each tick that wraps the index 3->0; value_in and half_sel are ignored at all other times.
REQ-012 SHALL use the freshly loaded snapshot for digit 0 of the new frame, so no frame shows digits from two different snapshots.
REQ-013 SHALL register an and seg; both change exactly one cycle after the tick that changed the index or snapshot.
REQ-014 SHALL drive an with only the bit of the current index low and seg with the hex pattern of snapshot nibble [4*index+3:4*index].
REQ-015 SHALL decode hex as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-016 SHALL pulse frame_done high for exactly one cycle, in the same cycle as the registered an/seg update for digit 0 that follows a 3->0 wrap.
REQ-017 SHALL have no handshake back-pressure: the display never stalls the CPU, and a value_in change mid-frame appears at the next frame boundary.

Reset
REQ-018 SHALL, on reset, clear the counter, index and snapshot to 0 and drive an=1110, seg=0000001, frame_done=0 in the following cycle.
REQ-019 SHALL give reset priority over a simultaneous tick; a frame interrupted by reset restarts at digit 0 with snapshot 0.

Configuration
REQ-020 SHALL, when macro SSD_LEADING_ZERO_BLANK_EN is defined, blank digits 3..1 (seg=1111111, an all ones) whose nibble and all more-significant nibbles of the snapshot are 0; digit 0 is never blanked.
REQ-021 SHALL, when SSD_LEADING_ZERO_BLANK_EN is undefined, display all four digits unconditionally; scan timing and frame_done are identical in both builds.

Structure
REQ-022 SHALL place the 16-entry hex-to-segment constant table and the blank pattern constant in the shared package ssd_pkg.
REQ-023 SHALL implement the decode as one combinational sub-module hex7seg (4-bit in, 7-bit out); counter, index, snapshot and output registers stay in ssd_scan.

Verification (REFRESH_DIV=4)
REQ-024 SHALL check reset: assert reset 3 cycles -> an=1110, seg=0000001, frame_done=0; first index advance 4 cycles after reset release.
REQ-025 SHALL check scan: value_in=0x0000_1234, half_sel=0 -> after first wrap, an sequence 1110,1101,1011,0111 each held 4 cycles with seg 1001100,0000110,0010010,1001111.
REQ-026 SHALL check half select: value_in=0xABCD_0000, half_sel=1 -> digits 0..3 show d,C,b,A; frame_done pulses every 16 cycles.
REQ-027 SHALL check tear-free update: change value_in 0x1111 -> 0x2222 during digit 2 -> digits 2,3 still show 1, next frame shows all 2.
REQ-028 SHALL check mid-frame reset: reset at digit 2 -> next cycle an=1110, seg=0000001, snapshot 0.
REQ-029 SHALL check blanking build: value_in=0x0000_0005 with SSD_LEADING_ZERO_BLANK_EN -> digits 3..1 seg=1111111 an=1111, digit 0 seg=0100100 an=1110; without macro, digits 3..1 show 0.
